// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI link constants and receiver state encoding
package spi_pkg;

   localparam int   SPI_DATA_W   = 11;
   localparam logic SPI_LOAD_ACT = 1'b0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-stage input synchroniser with registered copy for edge detection
module sync_edge #(
   parameter int   STG     = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STG-1:0] chain;
   logic           dly;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chain <= {STG{RST_VAL}};
         dly   <= RST_VAL;
      end else begin
         chain <= {chain[STG-2:0], din};
         dly   <= chain[STG-1];
      end
   end

   assign level = chain[STG-1];
   assign rise  = level & ~dly;
   assign fall  = ~level & dly;

endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI receive deserialiser: MSB-first frame to parallel word with valid/error strobes
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int   DATA_W   = SPI_DATA_W,
   parameter logic LOAD_ACT = SPI_LOAD_ACT,
   parameter int   SYNC_STG = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              LOAD,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic [DATA_W-1:0] rx_dat,
   output logic              rx_vld,
   output logic              frm_err,
   output logic              busy,
   output logic [3:0]        bit_cnt
);

   localparam logic [3:0] CNT_FULL = 4'(DATA_W);
   localparam logic [3:0] CNT_SAT  = 4'(DATA_W + 1);

   logic load_rise, load_fall, sclk_rise, sclk_fall, mosi_rise, mosi_fall;
   logic load_s, sclk_s, mosi_s;
   logic frm_start, frm_end;
   logic unused_edges;

   state_t            state, st_nxt;
   logic [DATA_W-1:0] shift_reg, sreg_nxt, dat_nxt;
   logic [3:0]        cnt_nxt;
   logic              vld_nxt, err_nxt;

   sync_edge #(.STG(SYNC_STG), .RST_VAL(~LOAD_ACT)) u_load (
      .clk(clk), .rst_n(rst_n), .din(LOAD), .level(load_s), .rise(load_rise), .fall(load_fall)
   );
   sync_edge #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .din(SCLK), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );
   sync_edge #(.STG(SYNC_STG), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst_n(rst_n), .din(MOSI), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_edges = ^{load_s, sclk_s, sclk_fall, mosi_rise, mosi_fall};
   assign frm_start    = LOAD_ACT ? load_rise : load_fall;
   assign frm_end      = LOAD_ACT ? load_fall : load_rise;
   assign busy         = (state == ST_SHIFT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         rx_dat    <= '0;
         rx_vld    <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         state     <= st_nxt;
         shift_reg <= sreg_nxt;
         bit_cnt   <= cnt_nxt;
         rx_dat    <= dat_nxt;
         rx_vld    <= vld_nxt;
         frm_err   <= err_nxt;
      end
   end

   // A bit arriving together with frm_end is counted before the frame is judged.
   always_comb begin
      st_nxt   = state;
      sreg_nxt = shift_reg;
      cnt_nxt  = bit_cnt;
      dat_nxt  = rx_dat;
      vld_nxt  = 1'b0;
      err_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (frm_start) begin
               st_nxt   = ST_SHIFT;
               sreg_nxt = '0;
               cnt_nxt  = '0;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               sreg_nxt = {shift_reg[DATA_W-2:0], mosi_s};
               if (bit_cnt != CNT_SAT) cnt_nxt = bit_cnt + 4'd1;
            end
            if (frm_end) begin
               st_nxt = ST_IDLE;
               if (cnt_nxt == CNT_FULL) begin
                  dat_nxt = sreg_nxt;
                  vld_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         default: st_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - scoreboard bench for spi_slave_rx with randomized frames
module tb_spi_slave_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        LOAD = 1'b1;
   logic        SCLK = 1'b0;
   logic        MOSI = 1'b0;
   logic [10:0] rx_dat;
   logic        rx_vld, frm_err, busy;
   logic [3:0]  bit_cnt;

   typedef struct {
      bit          is_err;
      logic [10:0] dat;
      logic [3:0]  cnt;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [10:0] ref_dat = '0;
   logic [3:0]  last_cnt = '0;

   spi_slave_rx dut (
      .clk(clk), .rst_n(rst_n), .LOAD(LOAD), .SCLK(SCLK), .MOSI(MOSI),
      .rx_dat(rx_dat), .rx_vld(rx_vld), .frm_err(frm_err), .busy(busy), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input int n, input logic [15:0] val);
      logic [15:0] v;
      v = val;
      for (int i = n - 1; i >= 0; i--) begin
         MOSI = v[i];
         tick(4);
         SCLK = 1'b1;
         tick(4);
         SCLK = 1'b0;
      end
   endtask

   // Model: only an exact DATA_W-bit frame delivers a word; others flag an error with a saturated count.
   task automatic frame(input int n, input logic [15:0] val);
      exp_t e;
      LOAD = 1'b0;
      tick(4);
      chk("busy_in_frame", {31'd0, busy}, 32'd1);
      send_bits(n, val);
      tick(3);
      LOAD = 1'b1;
      e.cyc = cyc + 3;
      e.cnt = (n > 12) ? 4'd12 : 4'(n);
      if (n == 11) begin
         ref_dat  = val[10:0];
         e.is_err = 1'b0;
      end else begin
         e.is_err = 1'b1;
      end
      e.dat    = ref_dat;
      last_cnt = e.cnt;
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_vld || frm_err) begin
            chk("vld_err_exclusive", {31'd0, rx_vld & frm_err}, 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_strobe", {30'd0, rx_vld, frm_err}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("strobe_kind", {31'd0, frm_err}, {31'd0, e.is_err});
               chk("rx_dat", {21'd0, rx_dat}, {21'd0, e.dat});
               chk("bit_cnt", {28'd0, bit_cnt}, {28'd0, e.cnt});
               chk("latency_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      int n;
      tick(3);
      chk("rst_rx_dat", {21'd0, rx_dat}, 32'd0);
      chk("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
      chk("rst_frm_err", {31'd0, frm_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_bit_cnt", {28'd0, bit_cnt}, 32'd0);
      rst_n = 1'b1;
      tick(3);

      frame(11, 16'h02CC);
      tick(6);
      frame(7, 16'h007F);
      tick(6);
      frame(13, 16'($urandom));
      tick(6);

      LOAD = 1'b0;
      tick(4);
      send_bits(5, 16'h001F);
      rst_n = 1'b0;
      tick(1);
      rst_n    = 1'b1;
      LOAD     = 1'b1;
      ref_dat  = '0;
      last_cnt = '0;
      chk("midrst_rx_dat", {21'd0, rx_dat}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_bit_cnt", {28'd0, bit_cnt}, 32'd0);
      tick(6);
      chk("midrst_quiet_busy", {31'd0, busy}, 32'd0);
      frame(11, 16'h0555);
      tick(6);

      frame(11, 16'h07FF);
      tick(2);
      frame(11, 16'h0001);
      tick(6);

      repeat (5) begin
         SCLK = 1'b1;
         tick(3);
         SCLK = 1'b0;
         tick(3);
      end
      tick(4);
      chk("noise_busy", {31'd0, busy}, 32'd0);
      chk("noise_bit_cnt", {28'd0, bit_cnt}, {28'd0, last_cnt});
      chk("noise_rx_dat", {21'd0, rx_dat}, {21'd0, ref_dat});

      repeat (12) begin
         n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 11;
         tick(int'($urandom_range(2, 5)));
         frame(n, 16'($urandom));
      end

      for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
      chk("scoreboard_drained", sb.size(), 32'd0);
      tick(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
